// File: rtl/jump_trap.sv
// jump_trap: watches Z80 operand reads after a JP nn opcode, captures
// the 16-bit target and raises a held trap when it matches the trap address.
module jump_trap #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        rd_n,
    input  logic [7:0]  data,
    input  logic        new_isr,
    input  logic        last_isr_jmp,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_sel,
    input  logic [7:0]  cfg_data,
    input  logic        trap_ack,
    output logic        trap,
    output logic [15:0] jmp_target,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_CMP,
        S_TRAP
    } state_t;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    state_t      state;
    state_t      state_nx;

    logic [1:0]  m1_sy;
    logic [1:0]  mreq_sy;
    logic [1:0]  rd_sy;
    logic        m1_d;
    logic        act_d;
    logic        samp;
    logic [7:0]  cap;
    logic [7:0]  cnt;
    logic [15:0] tgt;
    logic [15:0] trap_addr;
    logic        en;

    logic        m1_s;
    logic        act;
    logic        m1_rise;
    logic        m1_fall;
    logic        rd_end;
    logic        to_hit;
    logic        cnt_clr;
    logic        ld_lo;
    logic        ld_hi;
    logic        ld_tgt;

    assign m1_s    = m1_sy[1];
    assign act     = ~mreq_sy[1] & ~rd_sy[1] & m1_s;
    assign m1_rise = m1_s & ~m1_d;
    assign m1_fall = ~m1_s & m1_d;
    assign rd_end  = act_d & ~act;
    assign to_hit  = (cnt == TO_LIM);

    assign busy = (state == S_LO) || (state == S_HI);
    assign trap = (state == S_TRAP);

    // Strobe synchronizers idle high so reset never looks like bus activity
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m1_sy   <= 2'b11;
            mreq_sy <= 2'b11;
            rd_sy   <= 2'b11;
            m1_d    <= 1'b1;
            act_d   <= 1'b0;
            samp    <= 1'b0;
            cap     <= 8'h00;
        end else begin
            m1_sy   <= {m1_sy[0], m1_n};
            mreq_sy <= {mreq_sy[0], mreq_n};
            rd_sy   <= {rd_sy[0], rd_n};
            m1_d    <= m1_s;
            act_d   <= act;
            samp    <= m1_rise;
            if (act) begin
                cap <= data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Aborts take priority over a read-end landing in the same cycle
    always_comb begin
        state_nx = state;
        cnt_clr  = 1'b0;
        ld_lo    = 1'b0;
        ld_hi    = 1'b0;
        ld_tgt   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (samp && new_isr && last_isr_jmp) begin
                    state_nx = S_LO;
                    cnt_clr  = 1'b1;
                end
            end
            S_LO: begin
                if (m1_fall || to_hit) begin
                    state_nx = S_IDLE;
                end else if (rd_end) begin
                    state_nx = S_HI;
                    ld_lo    = 1'b1;
                    cnt_clr  = 1'b1;
                end
            end
            S_HI: begin
                if (m1_fall || to_hit) begin
                    state_nx = S_IDLE;
                end else if (rd_end) begin
                    state_nx = S_CMP;
                    ld_hi    = 1'b1;
                end
            end
            S_CMP: begin
                ld_tgt = 1'b1;
                if (en && (tgt == trap_addr)) begin
                    state_nx = S_TRAP;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_TRAP: begin
                if (trap_ack) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= 8'h00;
            tgt        <= 16'h0000;
            jmp_target <= 16'h0000;
        end else begin
            if (cnt_clr) begin
                cnt <= 8'h00;
            end else if (busy && (cnt != 8'hFF)) begin
                cnt <= cnt + 8'h01;
            end
            if (ld_lo) begin
                tgt[7:0] <= cap;
            end
            if (ld_hi) begin
                tgt[15:8] <= cap;
            end
            if (ld_tgt) begin
                jmp_target <= tgt;
            end
        end
    end

    // Compare in CMP sees pre-edge values since these update on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trap_addr <= 16'h0000;
            en        <= 1'b0;
        end else if (cfg_we) begin
            unique case (cfg_sel)
                2'd0:    trap_addr[7:0]  <= cfg_data;
                2'd1:    trap_addr[15:8] <= cfg_data;
                2'd2:    en              <= cfg_data[0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jump_trap.sv
// Directed self-checking bench for jump_trap: match, mismatch, disable,
// non-JP, aborts, timeout, reset in TRAP and config race in CMP.
module tb_jump_trap;

    logic        clk;
    logic        reset_n;
    logic        m1_n;
    logic        mreq_n;
    logic        rd_n;
    logic [7:0]  data;
    logic        new_isr;
    logic        last_isr_jmp;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [7:0]  cfg_data;
    logic        trap_ack;
    logic        trap;
    logic [15:0] jmp_target;
    logic        busy;

    int vectors = 0;
    int errs    = 0;

    jump_trap #(.TIMEOUT(255)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .m1_n         (m1_n),
        .mreq_n       (mreq_n),
        .rd_n         (rd_n),
        .data         (data),
        .new_isr      (new_isr),
        .last_isr_jmp (last_isr_jmp),
        .cfg_we       (cfg_we),
        .cfg_sel      (cfg_sel),
        .cfg_data     (cfg_data),
        .trap_ack     (trap_ack),
        .trap         (trap),
        .jmp_target   (jmp_target),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_data = d;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic jp_fetch(input logic ni, input logic jmp);
        m1_n   = 1'b0;
        mreq_n = 1'b0;
        rd_n   = 1'b0;
        idle(4);
        m1_n         = 1'b1;
        mreq_n       = 1'b1;
        rd_n         = 1'b1;
        new_isr      = ni;
        last_isr_jmp = jmp;
        idle(6);
        new_isr      = 1'b0;
        last_isr_jmp = 1'b0;
    endtask

    // Returns at the negedge where the strobes are released; data stays put
    task automatic bus_rd(input logic [7:0] b);
        data   = b;
        mreq_n = 1'b0;
        rd_n   = 1'b0;
        idle(4);
        mreq_n = 1'b1;
        rd_n   = 1'b1;
    endtask

    task automatic jp(input logic [7:0] lo, input logic [7:0] hi);
        jp_fetch(1'b1, 1'b1);
        bus_rd(lo);
        idle(5);
        bus_rd(hi);
        idle(6);
    endtask

    task automatic ack();
        trap_ack = 1'b1;
        @(negedge clk);
        trap_ack = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        m1_n         = 1'b1;
        mreq_n       = 1'b1;
        rd_n         = 1'b1;
        data         = 8'h00;
        new_isr      = 1'b0;
        last_isr_jmp = 1'b0;
        cfg_we       = 1'b0;
        cfg_sel      = 2'd0;
        cfg_data     = 8'h00;
        trap_ack     = 1'b0;
        idle(3);
        chk("rst_trap", {15'd0, trap}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_tgt", jmp_target, 16'h0000);
        reset_n = 1'b1;
        idle(2);

        // match with exact trap latency
        cfg(2'd0, 8'h00);
        cfg(2'd1, 8'h80);
        cfg(2'd2, 8'h01);
        jp_fetch(1'b1, 1'b1);
        chk("lo_busy", {15'd0, busy}, 16'd1);
        bus_rd(8'h00);
        idle(5);
        chk("hi_busy", {15'd0, busy}, 16'd1);
        bus_rd(8'h80);
        idle(2);
        chk("end_busy", {15'd0, busy}, 16'd1);
        idle(1);
        chk("cmp_trap", {15'd0, trap}, 16'd0);
        chk("cmp_busy", {15'd0, busy}, 16'd0);
        chk("cmp_tgt", jmp_target, 16'h0000);
        idle(1);
        chk("match_trap", {15'd0, trap}, 16'd1);
        chk("match_tgt", jmp_target, 16'h8000);
        idle(3);
        chk("trap_held", {15'd0, trap}, 16'd1);
        ack();
        chk("ack_clear", {15'd0, trap}, 16'd0);

        // mismatch
        jp(8'h34, 8'h12);
        chk("mis_tgt", jmp_target, 16'h1234);
        chk("mis_trap", {15'd0, trap}, 16'd0);

        // disabled
        cfg(2'd2, 8'h00);
        jp(8'h00, 8'h80);
        chk("dis_tgt", jmp_target, 16'h8000);
        chk("dis_trap", {15'd0, trap}, 16'd0);
        cfg(2'd2, 8'h01);
        cfg(2'd3, 8'h00);

        // non-JP opcode
        jp_fetch(1'b1, 1'b0);
        chk("nonjp_busy", {15'd0, busy}, 16'd0);
        bus_rd(8'h00);
        idle(5);
        bus_rd(8'h80);
        idle(6);
        chk("nonjp_trap", {15'd0, trap}, 16'd0);
        chk("nonjp_tgt", jmp_target, 16'h8000);

        // M1 fall abort after the low byte
        jp(8'h34, 8'h12);
        jp_fetch(1'b1, 1'b1);
        bus_rd(8'h00);
        idle(5);
        m1_n = 1'b0;
        idle(3);
        chk("abort_busy", {15'd0, busy}, 16'd0);
        m1_n = 1'b1;
        idle(5);
        bus_rd(8'h80);
        idle(6);
        chk("abort_trap", {15'd0, trap}, 16'd0);
        chk("abort_tgt", jmp_target, 16'h1234);

        // timeout in LO
        jp_fetch(1'b1, 1'b1);
        idle(200);
        chk("to_wait", {15'd0, busy}, 16'd1);
        idle(60);
        chk("to_idle", {15'd0, busy}, 16'd0);

        // config write in the CMP cycle only affects the next compare
        jp_fetch(1'b1, 1'b1);
        bus_rd(8'h00);
        idle(5);
        bus_rd(8'h80);
        idle(3);
        cfg(2'd0, 8'h01);
        chk("race_trap", {15'd0, trap}, 16'd1);
        ack();
        jp(8'h00, 8'h80);
        chk("race_next", {15'd0, trap}, 16'd0);
        chk("race_tgt", jmp_target, 16'h8000);

        // reset while in TRAP
        cfg(2'd0, 8'h00);
        jp(8'h00, 8'h80);
        chk("pre_rst_trap", {15'd0, trap}, 16'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_trap", {15'd0, trap}, 16'd0);
        chk("rst_mid_tgt", jmp_target, 16'h0000);
        idle(1);
        reset_n = 1'b1;
        idle(2);
        jp(8'h34, 8'h12);
        chk("post_rst_tgt", jmp_target, 16'h1234);
        jp(8'h00, 8'h00);
        chk("post_rst_dis", {15'd0, trap}, 16'd0);
        chk("post_rst_zero", jmp_target, 16'h0000);
        cfg(2'd2, 8'h01);
        jp(8'h00, 8'h00);
        chk("post_rst_en", {15'd0, trap}, 16'd1);
        ack();
        chk("post_rst_ack", {15'd0, trap}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
